// File: rtl/move_sequencer.sv
// move_sequencer: multi-cycle sequencer deciding PC hold/reload for wait and move instructions.
// Tracks move-source space and pulses the IO controller on memory/IO crossing moves.
`default_nettype none

module move_sequencer #(
  parameter int OP_WAIT   = 56,
  parameter int OP_MVSRC  = 57,
  parameter int OP_MVDST  = 59,
  parameter int IO_THRESH = 32764,
  parameter int PC_LIMIT  = 32764,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [5:0]        op_code,
  input  logic [ADDR_W-1:0] move_addr,
  input  logic [31:0]       pc_next,
  output logic              pc_stall,
  output logic              busy,
  output logic              src_is_mem,
  output logic              io_request,
  output logic              illegal_move,
  output logic              halted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [5:0]        C_WAIT  = 6'(OP_WAIT);
  localparam logic [5:0]        C_MVSRC = 6'(OP_MVSRC);
  localparam logic [5:0]        C_MVDST = 6'(OP_MVDST);
  localparam logic [ADDR_W-1:0] C_IO_TH = ADDR_W'(IO_THRESH);
  localparam logic [31:0]       C_PC_LM = 32'(PC_LIMIT);

  logic [1:0] state, state_nx;
  logic [1:0] rem, rem_nx;
  logic       io_move, io_move_nx;
  logic       dst_op, dst_op_nx;
  logic       src_nx, io_req_nx, illegal_nx, halted_nx;

  logic addr_io, at_limit, accept;

  assign addr_io  = move_addr > C_IO_TH;
  assign at_limit = pc_next >= C_PC_LM;

  // A decode that enters STALL; the halt check and IO->IO rejection pre-empt it.
  assign accept = (state == S_IDLE) && instr_valid && !at_limit &&
                  ((op_code == C_WAIT) || (op_code == C_MVSRC) ||
                   ((op_code == C_MVDST) && !(addr_io && !src_is_mem)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rem          <= 2'd0;
      io_move      <= 1'b0;
      dst_op       <= 1'b0;
      src_is_mem   <= 1'b0;
      io_request   <= 1'b0;
      illegal_move <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state        <= state_nx;
      rem          <= rem_nx;
      io_move      <= io_move_nx;
      dst_op       <= dst_op_nx;
      src_is_mem   <= src_nx;
      io_request   <= io_req_nx;
      illegal_move <= illegal_nx;
      halted       <= halted_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    rem_nx     = rem;
    io_move_nx = io_move;
    dst_op_nx  = dst_op;
    src_nx     = src_is_mem;
    io_req_nx  = 1'b0;
    illegal_nx = 1'b0;
    halted_nx  = halted;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          if (at_limit) begin
            state_nx  = S_HALT;
            halted_nx = 1'b1;
          end else if (op_code == C_WAIT) begin
            state_nx   = S_STALL;
            rem_nx     = 2'd0;
            io_move_nx = 1'b0;
            dst_op_nx  = 1'b0;
          end else if (op_code == C_MVSRC) begin
            state_nx   = S_STALL;
            rem_nx     = 2'd2;
            io_move_nx = 1'b0;
            dst_op_nx  = 1'b0;
            src_nx     = !addr_io;
          end else if (op_code == C_MVDST) begin
            if (addr_io && !src_is_mem) begin
              illegal_nx = 1'b1;
            end else begin
              state_nx  = S_STALL;
              dst_op_nx = 1'b1;
              // Only mem->mem needs the long stall; any IO crossing hands off to the IO controller.
              if (!addr_io && src_is_mem) begin
                rem_nx     = 2'd2;
                io_move_nx = 1'b0;
              end else begin
                rem_nx     = 2'd0;
                io_move_nx = 1'b1;
              end
            end
          end
        end
      end
      S_STALL: begin
        if (rem != 2'd0) begin
          rem_nx = rem - 2'd1;
        end else begin
          state_nx  = S_IDLE;
          io_req_nx = io_move;
          if (dst_op) src_nx = 1'b0;
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pc_stall = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE:  pc_stall = accept;
      S_STALL: begin
        pc_stall = (rem != 2'd0);
        busy     = 1'b1;
      end
      S_HALT:  pc_stall = 1'b1;
      default: pc_stall = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed vectors; expected per-cycle outputs are queued by the driver and checked by a monitor.
`default_nettype none

module tb_move_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [5:0]  op_code = 6'd0;
  logic [15:0] move_addr = 16'd0;
  logic [31:0] pc_next = 32'd0;
  logic        pc_stall, busy, src_is_mem, io_request, illegal_move, halted;

  int passed = 0;
  int total  = 0;

  // {pc_stall, busy, src_is_mem, io_request, illegal_move, halted}
  typedef struct {
    logic [5:0] exp;
    int         idx;
  } exp_t;
  exp_t exp_q[$];
  int   step_no = 0;

  move_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .op_code(op_code),
    .move_addr(move_addr), .pc_next(pc_next), .pc_stall(pc_stall), .busy(busy),
    .src_is_mem(src_is_mem), .io_request(io_request), .illegal_move(illegal_move),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic v, input logic [5:0] op,
                      input logic [15:0] a, input logic [31:0] pcn, input logic [5:0] e);
    @(posedge clk);
    #1;
    rst_n       = rn;
    instr_valid = v;
    op_code     = op;
    move_addr   = a;
    pc_next     = pcn;
    step_no++;
    exp_q.push_back('{exp: e, idx: step_no});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t       t;
      logic [5:0] act;
      t   = exp_q.pop_front();
      act = {pc_stall, busy, src_is_mem, io_request, illegal_move, halted};
      total++;
      if (act === t.exp) passed++;
      else $display("FAIL cycle%0d outputs{stall,busy,src,ioreq,illegal,halt}: got %b expected %b",
                    t.idx, act, t.exp);
    end
  end

  initial begin
    // reset held
    step(0, 0, 6'd0,  16'h0000, 0, 6'b000000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000000);
    // wait: stall 1,0; busy only in 2nd cycle
    step(1, 1, 6'd56, 16'h0000, 0, 6'b100000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b010000);
    // mvsrc 0x0100 (mem)
    step(1, 1, 6'd57, 16'h0100, 0, 6'b100000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b011000);
    // mvdst 0x0200 mem->mem, 4 cycles, no io_request
    step(1, 1, 6'd59, 16'h0200, 0, 6'b101000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b011000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000000);
    // mvsrc 0x0100 then mvdst 0x7FFF: mem->io
    step(1, 1, 6'd57, 16'h0100, 0, 6'b100000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b011000);
    step(1, 1, 6'd59, 16'h7FFF, 0, 6'b101000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b011000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000100);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000000);
    // mvsrc 0x7FFD (io) then mvdst 0x7FFC (mem boundary): io->mem
    step(1, 1, 6'd57, 16'h7FFD, 0, 6'b100000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b110000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b110000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b010000);
    step(1, 1, 6'd59, 16'h7FFC, 0, 6'b100000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b010000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000100);
    // io->io: illegal pulse, no stall
    step(1, 1, 6'd59, 16'h7FFF, 0, 6'b000000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000010);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000000);
    // mvsrc at boundary 0x7FFC is memory; back-to-back wait keeps src_is_mem
    step(1, 1, 6'd57, 16'h7FFC, 0, 6'b100000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b011000);
    step(1, 1, 6'd56, 16'h0000, 0, 6'b101000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b011000);
    // reset mid-mvsrc with rem=1
    step(1, 1, 6'd57, 16'h0100, 0, 6'b101000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b111000);
    step(0, 0, 6'd0,  16'h0000, 0, 6'b000000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000000);
    step(1, 1, 6'd56, 16'h0000, 0, 6'b100000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b010000);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b000000);
    // halt: limit wins over decode, then absorbing
    step(1, 1, 6'd56, 16'h0000, 32'd32764, 6'b000000);
    step(1, 1, 6'd56, 16'h0000, 0, 6'b100001);
    step(1, 1, 6'd59, 16'h7FFF, 0, 6'b100001);
    step(1, 1, 6'd57, 16'h0100, 0, 6'b100001);
    step(1, 0, 6'd0,  16'h0000, 0, 6'b100001);
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
